uart_core_param: RTL and testbench

//  Synthesizable, parametrised UART transceiver; successor to the behavioural TB UART.

---
 rtl/uart_pkg.sv | 53 +++++
 rtl/uart_sync_fifo.sv | 74 +++++++
 rtl/uart_core_param.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_uart_core_param.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types, FSM state encodings and helper functions for the
//             parametrised UART core and its RX FIFO.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

   // Parity mode as carried on cfg_parity_i; 2'b11 is treated as no parity.
   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10
   } parity_e;

   // TX FSM encoding
   typedef logic [2:0] tx_state_e;
   localparam tx_state_e TX_IDLE   = 3'd0;
   localparam tx_state_e TX_START  = 3'd1;
   localparam tx_state_e TX_DATA   = 3'd2;
   localparam tx_state_e TX_PARITY = 3'd3;
   localparam tx_state_e TX_STOP   = 3'd4;

   // RX FSM encoding
   typedef logic [2:0] rx_state_e;
   localparam rx_state_e RX_IDLE      = 3'd0;
   localparam rx_state_e RX_START     = 3'd1;
   localparam rx_state_e RX_DATA      = 3'd2;
   localparam rx_state_e RX_PARITY    = 3'd3;
   localparam rx_state_e RX_STOP      = 3'd4;
   localparam rx_state_e RX_WAIT_HIGH = 3'd5;

   // Widest payload supported; narrower payloads are zero-extended, which
   // leaves the XOR-based parity unchanged.
   localparam int MAX_DATA_BITS = 9;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic parity_en(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

   // Even parity makes the total count of ones even; odd is its complement.
   function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic [1:0] mode);
      return (mode == PAR_ODD) ? ~^data : ^data;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_sync_fifo
//  Purpose  : First-word fall-through synchronous FIFO with occupancy output
//             and a drop indication when a write meets a full FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module uart_sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     wr_valid_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   output logic                     wr_drop_o,
   output logic                     rd_valid_o,
   input  logic                     rd_ready_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q,  level_d;
   logic             w_full, w_push, w_pop;

   assign w_full     = (level_q == FULL_LEVEL);
   assign rd_valid_o = (level_q != '0);
   assign w_pop      = rd_valid_o & rd_ready_i;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign w_push     = wr_valid_i & (~w_full | w_pop);
   assign wr_drop_o  = wr_valid_i & w_full & ~w_pop;
   assign rd_data_o  = mem_q[rd_ptr_q];
   assign level_o    = level_q;

   // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   // Control registers; storage itself needs no reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage write port.
   always_ff @(posedge clk_i) begin
      if (w_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule
`default_nettype wire

// File: rtl/uart_core_param.sv
`default_nettype none
// ============================================================================
//  Module   : uart_core_param
//  Purpose  : Parametrised full-duplex UART: runtime baud divider, parity and
//             stop-bit selection, 3-sample majority RX and an RX FIFO whose
//             entries carry their own error flags.
//  Revision : 1.0  initial release
// ============================================================================
module uart_core_param
   import uart_pkg::*;
#(
   parameter int DATA_BITS     = 8,
   parameter int OVERSAMPLE    = 16,
   parameter int DIV_W         = 16,
   parameter int RX_FIFO_DEPTH = 8,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [DIV_W-1:0]                 cfg_div_i,
   input  logic [1:0]                       cfg_parity_i,
   input  logic                             cfg_stop2_i,
   input  logic                             cfg_rx_en_i,
   input  logic [DATA_BITS-1:0]             tx_data_i,
   input  logic                             tx_valid_i,
   output logic                             tx_ready_o,
   output logic                             tx_busy_o,
   output logic                             tx_o,
   input  logic                             rx_i,
   output logic [DATA_BITS-1:0]             rx_data_o,
   output logic                             rx_parity_err_o,
   output logic                             rx_frame_err_o,
   output logic                             rx_valid_o,
   input  logic                             rx_ready_i,
   output logic                             rx_overrun_o,
   output logic [$clog2(RX_FIFO_DEPTH):0]   rx_level_o
);

   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam int BI_W = $clog2(DATA_BITS);
   localparam int EW   = DATA_BITS + 2;
   localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0] S_PRE    = OS_W'(OVERSAMPLE/2 - 1);
   localparam logic [OS_W-1:0] S_MID    = OS_W'(OVERSAMPLE/2);
   localparam logic [OS_W-1:0] S_POST   = OS_W'(OVERSAMPLE/2 + 1);
   localparam logic [BI_W-1:0] BIT_LAST = BI_W'(DATA_BITS - 1);

   // ---------------------------------------------------------------- TX ----
   tx_state_e            tx_state_q, tx_state_d;
   logic [DIV_W-1:0]     tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
   logic [OS_W-1:0]      tx_os_q, tx_os_d;
   logic [BI_W-1:0]      tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic [1:0]           tx_par_q, tx_par_d;
   logic                 tx_stop2_q, tx_stop2_d;
   logic                 tx_pbit_q, tx_pbit_d;
   logic                 tx_o_q, tx_o_d;
   logic [MAX_DATA_BITS-1:0] w_tx_ext;
   logic                 w_tx_tick, w_tx_bit_end;

   assign tx_ready_o   = (tx_state_q == TX_IDLE);
   assign tx_busy_o    = ~tx_ready_o;
   assign tx_o         = tx_o_q;
   assign w_tx_tick    = (tx_cnt_q == '0);
   assign w_tx_bit_end = ~tx_ready_o & w_tx_tick & (tx_os_q == OS_LAST);

   // Zero-extend the TX payload for the shared parity helper.
   always_comb begin
      w_tx_ext = '0;
      w_tx_ext[DATA_BITS-1:0] = tx_data_i;
   end

   // TX frame sequencer: one bit per OVERSAMPLE ticks, cfg latched at accept.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_div_d   = tx_div_q;
      tx_os_d    = tx_os_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      tx_stop2_d = tx_stop2_q;
      tx_pbit_d  = tx_pbit_q;
      tx_o_d     = tx_o_q;
      if (tx_state_q == TX_IDLE) begin
         tx_o_d = 1'b1;
         if (tx_valid_i) begin
            tx_state_d = TX_START;
            tx_o_d     = 1'b0;
            tx_cnt_d   = cfg_div_i;
            tx_div_d   = cfg_div_i;
            tx_os_d    = '0;
            tx_bit_d   = '0;
            tx_shift_d = tx_data_i;
            tx_par_d   = cfg_parity_i;
            tx_stop2_d = cfg_stop2_i;
            tx_pbit_d  = parity_calc(w_tx_ext, cfg_parity_i);
         end
      end else begin
         tx_cnt_d = w_tx_tick ? tx_div_q : tx_cnt_q - DIV_W'(1);
         if (w_tx_tick) tx_os_d = w_tx_bit_end ? '0 : tx_os_q + OS_W'(1);
         if (w_tx_bit_end) begin
            case (tx_state_q)
               TX_START: begin
                  tx_state_d = TX_DATA;
                  tx_o_d     = tx_shift_q[0];
                  tx_shift_d = tx_shift_q >> 1;
               end
               TX_DATA: begin
                  if (tx_bit_q == BIT_LAST) begin
                     tx_bit_d = '0;
                     if (parity_en(tx_par_q)) begin
                        tx_state_d = TX_PARITY;
                        tx_o_d     = tx_pbit_q;
                     end else begin
                        tx_state_d = TX_STOP;
                        tx_o_d     = 1'b1;
                     end
                  end else begin
                     tx_bit_d   = tx_bit_q + BI_W'(1);
                     tx_o_d     = tx_shift_q[0];
                     tx_shift_d = tx_shift_q >> 1;
                  end
               end
               TX_PARITY: begin
                  tx_state_d = TX_STOP;
                  tx_o_d     = 1'b1;
               end
               TX_STOP: begin
                  if (tx_stop2_q && (tx_bit_q == '0)) tx_bit_d = BI_W'(1);
                  else                                tx_state_d = TX_IDLE;
               end
               default: tx_state_d = TX_IDLE;
            endcase
         end
      end
   end

   // TX state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_div_q   <= '0;
         tx_os_q    <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= PAR_NONE;
         tx_stop2_q <= 1'b0;
         tx_pbit_q  <= 1'b0;
         tx_o_q     <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_div_q   <= tx_div_d;
         tx_os_q    <= tx_os_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         tx_stop2_q <= tx_stop2_d;
         tx_pbit_q  <= tx_pbit_d;
         tx_o_q     <= tx_o_d;
      end
   end

   // ---------------------------------------------------------------- RX ----
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_prev_q;
   rx_state_e              rx_state_q, rx_state_d;
   logic [DIV_W-1:0]       rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
   logic [OS_W-1:0]        rx_os_q, rx_os_d;
   logic [BI_W-1:0]        rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
   logic [1:0]             rx_samp_q, rx_samp_d;
   logic [1:0]             rx_par_q, rx_par_d;
   logic                   rx_stop2_q, rx_stop2_d;
   logic                   rx_perr_q, rx_perr_d;
   logic                   rx_ferr_q, rx_ferr_d;
   logic                   push_q, push_d;
   logic [EW-1:0]          push_data_q, push_data_d;
   logic [EW-1:0]          w_head;
   logic [MAX_DATA_BITS-1:0] w_rx_ext;
   logic                   w_rx, w_rx_tick, w_rx_active, w_rx_bit_end, w_sample, w_maj, w_ferr;

   assign w_rx         = sync_q[SYNC_STAGES-1];
   assign w_rx_tick    = (rx_cnt_q == '0);
   assign w_rx_active  = (rx_state_q != RX_IDLE) && (rx_state_q != RX_WAIT_HIGH);
   assign w_rx_bit_end = w_rx_active & w_rx_tick & (rx_os_q == OS_LAST);
   assign w_sample     = w_rx_active & w_rx_tick & (rx_os_q == S_POST);
   assign w_maj        = majority3(rx_samp_q[1], rx_samp_q[0], w_rx);
   assign w_ferr       = rx_ferr_q | ~w_maj;

   // Zero-extend the received payload for the shared parity helper.
   always_comb begin
      w_rx_ext = '0;
      w_rx_ext[DATA_BITS-1:0] = rx_shift_q;
   end

   // Input synchroniser and edge-detect history; idle-high after reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q    <= '1;
         rx_prev_q <= 1'b1;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
         rx_prev_q <= w_rx;
      end
   end

   // RX frame sequencer: majority sample around mid-bit, finish at mid-stop.
   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      rx_div_d    = rx_div_q;
      rx_os_d     = rx_os_q;
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      rx_samp_d   = rx_samp_q;
      rx_par_d    = rx_par_q;
      rx_stop2_d  = rx_stop2_q;
      rx_perr_d   = rx_perr_q;
      rx_ferr_d   = rx_ferr_q;
      push_d      = 1'b0;
      push_data_d = push_data_q;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev_q && !w_rx && cfg_rx_en_i) begin
               rx_state_d = RX_START;
               rx_cnt_d   = cfg_div_i;
               rx_div_d   = cfg_div_i;
               rx_os_d    = '0;
               rx_bit_d   = '0;
               rx_par_d   = cfg_parity_i;
               rx_stop2_d = cfg_stop2_i;
               rx_perr_d  = 1'b0;
               rx_ferr_d  = 1'b0;
            end
         end
         RX_WAIT_HIGH: begin
            if (w_rx) rx_state_d = RX_IDLE;
         end
         default: begin
            rx_cnt_d = w_rx_tick ? rx_div_q : rx_cnt_q - DIV_W'(1);
            if (w_rx_tick) begin
               rx_os_d = w_rx_bit_end ? '0 : rx_os_q + OS_W'(1);
               if (rx_os_q == S_PRE) rx_samp_d[1] = w_rx;
               if (rx_os_q == S_MID) rx_samp_d[0] = w_rx;
            end
            case (rx_state_q)
               RX_START: begin
                  if (w_sample && w_maj) rx_state_d = RX_IDLE;
                  else if (w_rx_bit_end) rx_state_d = RX_DATA;
               end
               RX_DATA: begin
                  if (w_sample) rx_shift_d = {w_maj, rx_shift_q[DATA_BITS-1:1]};
                  if (w_rx_bit_end) begin
                     if (rx_bit_q == BIT_LAST) begin
                        rx_bit_d   = '0;
                        rx_state_d = parity_en(rx_par_q) ? RX_PARITY : RX_STOP;
                     end else begin
                        rx_bit_d = rx_bit_q + BI_W'(1);
                     end
                  end
               end
               RX_PARITY: begin
                  if (w_sample) rx_perr_d = (w_maj != parity_calc(w_rx_ext, rx_par_q));
                  if (w_rx_bit_end) rx_state_d = RX_STOP;
               end
               RX_STOP: begin
                  if (w_sample) begin
                     rx_ferr_d = w_ferr;
                     if (!(rx_stop2_q && (rx_bit_q == '0))) begin
                        push_d      = 1'b1;
                        push_data_d = {rx_perr_q, w_ferr, rx_shift_q};
                        // All-zero data with a bad stop is a line break.
                        rx_state_d  = (w_ferr && (rx_shift_q == '0)) ? RX_WAIT_HIGH : RX_IDLE;
                     end
                  end
                  if (w_rx_bit_end) rx_bit_d = BI_W'(1);
               end
               default: rx_state_d = RX_IDLE;
            endcase
         end
      endcase
      if (!cfg_rx_en_i) rx_state_d = RX_IDLE;
   end

   // RX state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_state_q  <= RX_IDLE;
         rx_cnt_q    <= '0;
         rx_div_q    <= '0;
         rx_os_q     <= '0;
         rx_bit_q    <= '0;
         rx_shift_q  <= '0;
         rx_samp_q   <= '0;
         rx_par_q    <= PAR_NONE;
         rx_stop2_q  <= 1'b0;
         rx_perr_q   <= 1'b0;
         rx_ferr_q   <= 1'b0;
         push_q      <= 1'b0;
         push_data_q <= '0;
      end else begin
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_div_q    <= rx_div_d;
         rx_os_q     <= rx_os_d;
         rx_bit_q    <= rx_bit_d;
         rx_shift_q  <= rx_shift_d;
         rx_samp_q   <= rx_samp_d;
         rx_par_q    <= rx_par_d;
         rx_stop2_q  <= rx_stop2_d;
         rx_perr_q   <= rx_perr_d;
         rx_ferr_q   <= rx_ferr_d;
         push_q      <= push_d;
         push_data_q <= push_data_d;
      end
   end

   uart_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (RX_FIFO_DEPTH)
   ) u_rx_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_valid_i (push_q),
      .wr_data_i  (push_data_q),
      .wr_drop_o  (rx_overrun_o),
      .rd_valid_o (rx_valid_o),
      .rd_ready_i (rx_ready_i),
      .rd_data_o  (w_head),
      .level_o    (rx_level_o)
   );

   assign rx_data_o       = w_head[DATA_BITS-1:0];
   assign rx_frame_err_o  = w_head[DATA_BITS];
   assign rx_parity_err_o = w_head[DATA_BITS+1];

endmodule
`default_nettype wire

// File: tb/tb_uart_core_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_core_param
//  Purpose  : Directed self-checking bench for uart_core_param (8 data bits,
//             OVERSAMPLE 16, RX FIFO depth 8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_core_param;

   localparam int DB = 8;
   localparam int OS = 16;
   localparam int DW = 16;
   localparam int D  = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] cfg_div;
   logic [1:0]    cfg_parity;
   logic          cfg_stop2, cfg_rx_en;
   logic [DB-1:0] tx_data;
   logic          tx_valid, tx_ready, tx_busy, tx_o;
   logic          rx_line, rx_drv, loop_en;
   logic [DB-1:0] rx_data;
   logic          rx_perr, rx_ferr, rx_valid, rx_ready, rx_overrun;
   logic [3:0]    rx_level;

   int n_tests = 0;
   int n_fail  = 0;
   int ovr_cnt = 0;

   always #5 clk = ~clk;
   assign rx_line = loop_en ? tx_o : rx_drv;

   // Count overrun pulses so frame-level checks can look at deltas.
   always @(negedge clk) if (rx_overrun) ovr_cnt <= ovr_cnt + 1;

   uart_core_param #(.DATA_BITS(DB), .OVERSAMPLE(OS), .DIV_W(DW),
                     .RX_FIFO_DEPTH(D), .SYNC_STAGES(2)) dut (
      .clk_i(clk), .rst_i(rst), .cfg_div_i(cfg_div), .cfg_parity_i(cfg_parity),
      .cfg_stop2_i(cfg_stop2), .cfg_rx_en_i(cfg_rx_en), .tx_data_i(tx_data),
      .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_busy_o(tx_busy),
      .tx_o(tx_o), .rx_i(rx_line), .rx_data_o(rx_data),
      .rx_parity_err_o(rx_perr), .rx_frame_err_o(rx_ferr),
      .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
      .rx_overrun_o(rx_overrun), .rx_level_o(rx_level));

   typedef struct {
      logic [7:0] d;
      logic [1:0] pm;
      logic       s2;
      logic       bad_par;
      int         bad_stop;
      int         extra_low;
      logic [7:0] ed;
      logic       ep;
      logic       ef;
   } rxvec_t;

   rxvec_t vec [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic rx_bit(input logic v, input int cyc);
      rx_drv = v;
      repeat (cyc) @(posedge clk);
      #1;
   endtask

   // Drive one serial frame on rx_drv; bad_stop selects which stop bit is 0.
   task automatic send_rx(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                          input logic bad_par, input int bad_stop, input int extra_low);
      int   bc;
      logic p;
      bc = OS * (int'(cfg_div) + 1);
      rx_bit(1'b0, bc);
      for (int i = 0; i < 8; i++) rx_bit(d[i], bc);
      if (pm == 2'b01 || pm == 2'b10) begin
         p = (pm == 2'b10) ? ~^d : ^d;
         if (bad_par) p = ~p;
         rx_bit(p, bc);
      end
      rx_bit((bad_stop == 1) ? 1'b0 : 1'b1, bc);
      if (s2) rx_bit((bad_stop == 2) ? 1'b0 : 1'b1, bc);
      if (extra_low > 0) rx_bit(1'b0, extra_low);
      rx_bit(1'b1, bc);
   endtask

   task automatic pop_check(input string name, input logic [7:0] ed, input logic ep, input logic ef);
      @(negedge clk);
      check({name, "_valid"}, {31'd0, rx_valid}, 32'd1);
      check(name, {22'd0, rx_perr, rx_ferr, rx_data}, {22'd0, ep, ef, ed});
      rx_ready = 1'b1;
      @(posedge clk);
      #1;
      rx_ready = 1'b0;
   endtask

   task automatic wait_tx_ready(input string name, input int lim);
      int k;
      k = 0;
      while (!tx_ready && k < lim) begin
         @(posedge clk);
         k++;
      end
      #1;
      check(name, {31'd0, (k < lim)}, 32'd1);
   endtask

   task automatic tx_send(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] bits;
      logic [9:0] bad;
      int         base;

      vec[0] = '{8'h41, 2'b01, 1'b0, 1'b1, 0, 0,  8'h41, 1'b1, 1'b0};
      vec[1] = '{8'h55, 2'b00, 1'b0, 1'b0, 0, 0,  8'h55, 1'b0, 1'b0};
      vec[2] = '{8'hA3, 2'b10, 1'b0, 1'b0, 0, 0,  8'hA3, 1'b0, 1'b0};
      vec[3] = '{8'h80, 2'b01, 1'b1, 1'b0, 2, 0,  8'h80, 1'b0, 1'b1};
      vec[4] = '{8'h00, 2'b00, 1'b0, 1'b0, 1, 48, 8'h00, 1'b0, 1'b1};
      vec[5] = '{8'h7E, 2'b11, 1'b1, 1'b0, 0, 0,  8'h7E, 1'b0, 1'b0};

      rst = 1'b1; cfg_div = '0; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
      cfg_rx_en = 1'b1; tx_data = '0; tx_valid = 1'b0; rx_drv = 1'b1;
      loop_en = 1'b0; rx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("reset_outputs", {26'd0, tx_o, tx_ready, tx_busy, rx_valid, rx_overrun, 1'b0},
            {26'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      check("reset_level", {28'd0, rx_level}, 32'd0);

      // TX 0xA5 8N1: frame occupies cycles 1..160 after the accept edge
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = (8'hA5 >> i) & 1'b1;
      bits[9] = 1'b1;
      bad = '0;
      @(posedge clk); #1;
      tx_send(8'hA5);
      for (int c = 1; c <= 160; c++) begin
         @(negedge clk);
         if (tx_o !== bits[(c-1)/16]) bad[(c-1)/16] = 1'b1;
         if (c == 80) check("tx_busy_mid", {31'd0, tx_busy}, 32'd1);
         if (c == 160) check("tx_ready_c160", {31'd0, tx_ready}, 32'd0);
      end
      for (int b = 0; b < 10; b++) check($sformatf("tx_a5_bit%0d", b), {31'd0, bad[b]}, 32'd0);
      @(negedge clk);
      check("tx_ready_c161", {31'd0, tx_ready}, 32'd1);
      @(posedge clk); #1;

      // Table-driven RX frames, each popped right after reception
      for (int v = 0; v < 6; v++) begin
         cfg_parity = vec[v].pm;
         cfg_stop2  = vec[v].s2;
         send_rx(vec[v].d, vec[v].pm, vec[v].s2, vec[v].bad_par, vec[v].bad_stop, vec[v].extra_low);
         pop_check($sformatf("rxvec%0d", v), vec[v].ed, vec[v].ep, vec[v].ef);
      end
      cfg_stop2 = 1'b0; cfg_parity = 2'b00;

      // Start glitch: 5 low cycles, no push, then a valid 0x55
      rx_bit(1'b0, 5);
      rx_bit(1'b1, 64);
      @(negedge clk);
      check("glitch_level", {28'd0, rx_level}, 32'd0);
      @(posedge clk); #1;
      send_rx(8'h55, 2'b00, 1'b0, 1'b0, 0, 0);
      pop_check("after_glitch", 8'h55, 1'b0, 1'b0);

      // Loopback 8E2 with divider 3
      cfg_div = 16'd3; cfg_parity = 2'b01; cfg_stop2 = 1'b1; loop_en = 1'b1;
      @(posedge clk); #1;
      wait_tx_ready("lb_ready0", 5000); tx_send(8'h00);
      wait_tx_ready("lb_ready1", 5000); tx_send(8'hFF);
      wait_tx_ready("lb_ready2", 5000); tx_send(8'h3C);
      wait_tx_ready("lb_ready3", 5000);
      repeat (20) @(posedge clk); #1;
      pop_check("lb_00", 8'h00, 1'b0, 1'b0);
      pop_check("lb_ff", 8'hFF, 1'b0, 1'b0);
      pop_check("lb_3c", 8'h3C, 1'b0, 1'b0);
      loop_en = 1'b0; cfg_div = '0; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
      @(posedge clk); #1;

      // Overrun: nine frames into an eight-entry FIFO with no pops
      base = ovr_cnt;
      for (int i = 1; i <= 8; i++) send_rx(8'(i), 2'b00, 1'b0, 1'b0, 0, 0);
      @(negedge clk);
      check("ovr_none_before", ovr_cnt - base, 32'd0);
      check("level_full", {28'd0, rx_level}, 32'd8);
      @(posedge clk); #1;
      send_rx(8'h09, 2'b00, 1'b0, 1'b0, 0, 0);
      @(negedge clk);
      check("ovr_pulse", ovr_cnt - base, 32'd1);
      check("level_after_ovr", {28'd0, rx_level}, 32'd8);
      @(posedge clk); #1;
      for (int i = 1; i <= 8; i++) pop_check($sformatf("ovr_pop%0d", i), 8'(i), 1'b0, 1'b0);
      @(negedge clk);
      check("ovr_empty", {31'd0, rx_valid}, 32'd0);
      @(posedge clk); #1;

      // Reset during a TX data bit
      tx_send(8'h00);
      repeat (24) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_tx_o", {31'd0, tx_o}, 32'd1);
      check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
      @(posedge clk); #1;

      // Reset during an RX data bit: partial frame must not be pushed
      fork
         send_rx(8'hFF, 2'b00, 1'b0, 1'b0, 0, 0);
         begin
            repeat (40) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
         end
      join
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("rst_rx_level", {28'd0, rx_level}, 32'd0);
      check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
